// File: rtl/alu_issue_if.sv
// Handshake and ALU-side signal bundle for alu_issue.
// master = instruction source / ALU / result consumer, slave = alu_issue.
interface alu_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] pc;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_y;
  logic [1:0]  alu_flags;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [4:0]  dest_reg;
  logic        wr_en;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        illegal;

  modport master (
    output in_valid, instr, rs_val, rt_val, pc, alu_y, alu_flags, out_ready,
    input  in_ready, alu_a, alu_b, alu_op, out_valid, result, dest_reg,
           wr_en, branch_taken, branch_target, illegal
  );

  modport slave (
    input  in_valid, instr, rs_val, rt_val, pc, alu_y, alu_flags, out_ready,
    output in_ready, alu_a, alu_b, alu_op, out_valid, result, dest_reg,
           wr_en, branch_taken, branch_target, illegal
  );
endinterface

// File: rtl/alu_issue.sv
// EX-stage issue logic: decodes a MIPS instruction, drives the ALU for one cycle,
// captures y/flags and returns write-back/branch info. Optional jal via ALU_ISSUE_JAL_EN.
module alu_issue (
  input  logic       clk,
  input  logic       rst_n,
  alu_issue_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;
  typedef enum logic [2:0] {BR_NONE, BR_EQ, BR_NE, BR_LEZ, BR_GTZ, BR_JAL} br_e;

  state_e      state_q, state_d;
  br_e         br_q, br_d;
  logic [31:0] alu_a_q, alu_a_d;
  logic [31:0] alu_b_q, alu_b_d;
  logic [3:0]  alu_op_q, alu_op_d;
  logic [31:0] result_q, result_d;
  logic [31:0] target_q, target_d;
  logic [4:0]  dest_q, dest_d;
  logic        out_valid_q, out_valid_d;
  logic        wr_en_q, wr_en_d;
  logic        taken_q, taken_d;
  logic        illegal_q, illegal_d;

  logic [5:0]  opcode, funct;
  logic [4:0]  shamt, rt_idx, rd_idx;
  logic [31:0] imm_sext, imm_zext, imm_hi;
  logic [3:0]  dec_op;
  logic [31:0] dec_a, dec_b, dec_target;
  logic [4:0]  dec_dest;
  logic        dec_ill, dec_wr;
  br_e         dec_br;
  logic        in_ready, accept;

  assign opcode   = bus.instr[31:26];
  assign rt_idx   = bus.instr[20:16];
  assign rd_idx   = bus.instr[15:11];
  assign shamt    = bus.instr[10:6];
  assign funct    = bus.instr[5:0];
  assign imm_sext = {{16{bus.instr[15]}}, bus.instr[15:0]};
  assign imm_zext = {16'h0000, bus.instr[15:0]};
  assign imm_hi   = {bus.instr[15:0], 16'h0000};

  always_comb begin
    dec_op     = 4'b1010;
    dec_a      = bus.rs_val;
    dec_b      = bus.rt_val;
    dec_dest   = rt_idx;
    dec_ill    = 1'b0;
    dec_br     = BR_NONE;
    dec_target = bus.pc + 32'd4 + {imm_sext[29:0], 2'b00};
    case (opcode)
      6'h00: begin
        dec_dest = rd_idx;
        case (funct)
          6'h20, 6'h21: dec_op = 4'b0000;
          6'h22, 6'h23: dec_op = 4'b0001;
          6'h24:        dec_op = 4'b0010;
          6'h25:        dec_op = 4'b0011;
          6'h26:        dec_op = 4'b0100;
          6'h27:        dec_op = 4'b0101;
          6'h2A:        dec_op = 4'b1001;
          6'h00: begin dec_op = 4'b0110; dec_a = {27'd0, shamt}; end
          6'h02: begin dec_op = 4'b0111; dec_a = {27'd0, shamt}; end
          6'h03: begin dec_op = 4'b1000; dec_a = {27'd0, shamt}; end
          6'h04:        dec_op = 4'b0110;
          6'h06:        dec_op = 4'b0111;
          6'h07:        dec_op = 4'b1000;
          default:      dec_ill = 1'b1;
        endcase
      end
      6'h08, 6'h09: begin dec_op = 4'b0000; dec_b = imm_sext; end
      6'h0A:        begin dec_op = 4'b1001; dec_b = imm_sext; end
      6'h0C:        begin dec_op = 4'b0010; dec_b = imm_zext; end
      6'h0D:        begin dec_op = 4'b0011; dec_b = imm_zext; end
      6'h0E:        begin dec_op = 4'b0100; dec_b = imm_zext; end
      6'h0F:        begin dec_op = 4'b1011; dec_b = imm_hi; end
      6'h04: begin dec_op = 4'b0001; dec_dest = '0; dec_br = BR_EQ; end
      6'h05: begin dec_op = 4'b0001; dec_dest = '0; dec_br = BR_NE; end
      6'h06: begin dec_op = 4'b1010; dec_b = '0; dec_dest = '0; dec_br = BR_LEZ; end
      6'h07: begin dec_op = 4'b1010; dec_b = '0; dec_dest = '0; dec_br = BR_GTZ; end
`ifdef ALU_ISSUE_JAL_EN
      6'h03: begin
        dec_op     = 4'b1100;
        dec_a      = '0;
        dec_b      = bus.pc;
        dec_dest   = 5'd31;
        dec_br     = BR_JAL;
        dec_target = {bus.pc[31:28], bus.instr[25:0], 2'b00};
      end
`endif
      default: dec_ill = 1'b1;
    endcase
    if (dec_ill) begin
      dec_op   = 4'b1010;
      dec_a    = '0;
      dec_b    = '0;
      dec_dest = '0;
      dec_br   = BR_NONE;
    end
    dec_wr = !dec_ill && (dec_br == BR_NONE || dec_br == BR_JAL) && (dec_dest != 5'd0);
  end

  // DONE hands the input slot straight through when the result is being consumed.
  assign in_ready = (state_q == IDLE) || (state_q == DONE && bus.out_ready);
  assign accept   = in_ready && bus.in_valid;

  always_comb begin
    state_d     = state_q;
    br_d        = br_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    result_d    = result_q;
    target_d    = target_q;
    dest_d      = dest_q;
    out_valid_d = out_valid_q;
    wr_en_d     = wr_en_q;
    taken_d     = taken_q;
    illegal_d   = illegal_q;
    case (state_q)
      EXEC: begin
        state_d     = DONE;
        out_valid_d = 1'b1;
        result_d    = bus.alu_y;
        case (br_q)
          BR_EQ:   taken_d = bus.alu_flags[0];
          BR_NE:   taken_d = !bus.alu_flags[0];
          BR_LEZ:  taken_d = bus.alu_flags[0] | bus.alu_flags[1];
          BR_GTZ:  taken_d = !bus.alu_flags[0] & !bus.alu_flags[1];
          BR_JAL:  taken_d = 1'b1;
          default: taken_d = 1'b0;
        endcase
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: ;
    endcase
    if (accept) begin
      state_d   = EXEC;
      br_d      = dec_br;
      alu_a_d   = dec_a;
      alu_b_d   = dec_b;
      alu_op_d  = dec_op;
      target_d  = dec_target;
      dest_d    = dec_dest;
      wr_en_d   = dec_wr;
      taken_d   = 1'b0;
      illegal_d = dec_ill;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      br_q        <= BR_NONE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      result_q    <= '0;
      target_q    <= '0;
      dest_q      <= '0;
      out_valid_q <= 1'b0;
      wr_en_q     <= 1'b0;
      taken_q     <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      br_q        <= br_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      result_q    <= result_d;
      target_q    <= target_d;
      dest_q      <= dest_d;
      out_valid_q <= out_valid_d;
      wr_en_q     <= wr_en_d;
      taken_q     <= taken_d;
      illegal_q   <= illegal_d;
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.alu_a         = alu_a_q;
  assign bus.alu_b         = alu_b_q;
  assign bus.alu_op        = alu_op_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.result        = result_q;
  assign bus.dest_reg      = dest_q;
  assign bus.wr_en         = wr_en_q;
  assign bus.branch_taken  = taken_q;
  assign bus.branch_target = target_q;
  assign bus.illegal       = illegal_q;

endmodule
